// File: rtl/player_motion_pkg.sv
// Shared movement command codes and player FSM encodings.
// The keypad decoder uses the same MV_* codes.
package player_motion_pkg;

    localparam logic [2:0] MV_NONE   = 3'b000;
    localparam logic [2:0] MV_BIG    = 3'b001;
    localparam logic [2:0] MV_SMALL  = 3'b010;
    localparam logic [2:0] MV_CROUCH = 3'b011;
    localparam logic [2:0] MV_DROP   = 3'b100;

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_CROUCH = 2'd1;
    localparam logic [1:0] ST_AIR    = 2'd2;

    // Sign bit plus enough magnitude bits for the larger of the two speed limits.
    function automatic int vel_width(input int big_v, input int drop_v);
        return 1 + $clog2(((big_v > drop_v) ? big_v : drop_v) + 1);
    endfunction

endpackage

// File: rtl/motion_cmd_latch.sv
// Holds the most recent jump/drop pulse until the next frame tick.
// A pulse arriving together with the tick is forwarded straight to cmd_o.
module motion_cmd_latch
    import player_motion_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] movement,
    input  logic       frame_tick,
    input  logic       clear_i,
    output logic [2:0] cmd_o
);

    logic [2:0] pend_q, pend_d;
    logic       is_pulse;

    assign is_pulse = (movement == MV_BIG) || (movement == MV_SMALL) ||
                      (movement == MV_DROP);

    always_comb begin
        pend_d = pend_q;
        if (is_pulse)
            pend_d = movement;
        // Every tick consumes or discards whatever is pending.
        if (frame_tick || clear_i)
            pend_d = MV_NONE;
    end

    assign cmd_o = clear_i  ? MV_NONE  :
                   is_pulse ? movement : pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pend_q <= MV_NONE;
        else
            pend_q <= pend_d;
    end

endmodule

// File: rtl/player_motion.sv
// Per-frame vertical integrator and GROUND/CROUCH/AIR state machine for the player sprite.
// Crouch follows the command level every clk; jumps, drops and motion act only on frame_tick.
module player_motion
    import player_motion_pkg::*;
#(
    parameter int Y_W      = 7,
    parameter int GROUND_Y = 100,
    parameter int BIG_V    = 6,
    parameter int SMALL_V  = 4,
    parameter int GRAVITY  = 1,
    parameter int DROP_V   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     movement,
    input  logic           frame_tick,
    output logic [Y_W-1:0] player_y,
    output logic           airborne,
    output logic           crouching,
    output logic           landed,
    output logic [1:0]     dbg_state_o
);

    localparam int VW = vel_width(BIG_V, DROP_V);
    localparam int AW = Y_W + 2;

    localparam logic signed [AW-1:0] NEG_DROP = AW'(-DROP_V);
    localparam logic signed [AW-1:0] GROUND_S = AW'(GROUND_Y);
    localparam logic signed [AW-1:0] GRAV_S   = AW'(GRAVITY);

    logic [1:0]           state_q, state_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic                 landed_q, landed_d;
    logic [2:0]           cmd;

    logic signed [AW-1:0] vel_eff, y_next, vel_dec, vel_sat;

    motion_cmd_latch u_cmd_latch (
        .clk        (clk),
        .reset      (reset),
        .movement   (movement),
        .frame_tick (frame_tick),
        .clear_i    (state_q == ST_CROUCH),
        .cmd_o      (cmd)
    );

    // All airborne arithmetic is signed and wide enough to see both overshoots.
    assign vel_eff = (cmd == MV_DROP) ? NEG_DROP : AW'(vel_q);
    assign y_next  = $signed({2'b00, y_q}) - vel_eff;
    assign vel_dec = vel_eff - GRAV_S;
    assign vel_sat = (vel_dec < NEG_DROP) ? NEG_DROP : vel_dec;

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vel_d    = vel_q;
        landed_d = 1'b0;
        case (state_q)
            ST_GROUND: begin
                // A jump already due on this tick takes priority over a new crouch.
                if (frame_tick && cmd == MV_BIG) begin
                    y_d     = Y_W'(GROUND_Y - BIG_V);
                    vel_d   = VW'(BIG_V - GRAVITY);
                    state_d = ST_AIR;
                end else if (frame_tick && cmd == MV_SMALL) begin
                    y_d     = Y_W'(GROUND_Y - SMALL_V);
                    vel_d   = VW'(SMALL_V - GRAVITY);
                    state_d = ST_AIR;
                end else if (movement == MV_CROUCH) begin
                    state_d = ST_CROUCH;
                end
            end
            ST_CROUCH: begin
                if (movement != MV_CROUCH)
                    state_d = ST_GROUND;
            end
            ST_AIR: begin
                if (frame_tick) begin
                    if (y_next >= GROUND_S) begin
                        y_d      = Y_W'(GROUND_Y);
                        vel_d    = '0;
                        state_d  = ST_GROUND;
                        landed_d = 1'b1;
                    end else if (y_next[AW-1]) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else begin
                        y_d   = Y_W'(y_next);
                        vel_d = VW'(vel_sat);
                    end
                end
            end
            default: state_d = ST_GROUND;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_GROUND;
            y_q      <= Y_W'(GROUND_Y);
            vel_q    <= '0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            landed_q <= landed_d;
        end
    end

    assign player_y    = y_q;
    assign airborne    = (state_q == ST_AIR);
    assign crouching   = (state_q == ST_CROUCH);
    assign landed      = landed_q;
    assign dbg_state_o = state_q;

endmodule
